// File: rtl/change_dispenser.sv
// Greedy change dispenser: breaks a 10-bit amount (1 LSB = 10 sen) into tokens
// and ejects them one at a time over a req/ack handshake with jam detection.
module change_dispenser #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned TW          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] change,
  input  logic       start,
  input  logic       ejAck,
  input  logic       clrFault,
  output logic [5:0] eject,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [9:0] remaining,
  output logic [9:0] dispensed
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_RELEASE,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  state_t        state_q, state_d;
  logic [5:0]    eject_q, eject_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  logic [9:0]    remaining_q, remaining_d;
  logic [9:0]    dispensed_q, dispensed_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [5:0]    pick_onehot;
  logic [9:0]    token_value;

  // Largest denomination not exceeding the amount still owed.
  always_comb begin
    if (remaining_q >= 10'd100)     pick_onehot = 6'b100000;
    else if (remaining_q >= 10'd50) pick_onehot = 6'b010000;
    else if (remaining_q >= 10'd10) pick_onehot = 6'b001000;
    else if (remaining_q >= 10'd5)  pick_onehot = 6'b000100;
    else if (remaining_q >= 10'd2)  pick_onehot = 6'b000010;
    else                            pick_onehot = 6'b000001;
  end

  always_comb begin
    unique case (eject_q)
      6'b100000: token_value = 10'd100;
      6'b010000: token_value = 10'd50;
      6'b001000: token_value = 10'd10;
      6'b000100: token_value = 10'd5;
      6'b000010: token_value = 10'd2;
      6'b000001: token_value = 10'd1;
      default:   token_value = 10'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    eject_d     = eject_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fault_d     = fault_q;
    remaining_d = remaining_q;
    dispensed_d = dispensed_q;
    timer_d     = timer_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (change != 10'd0) begin
            remaining_d = change;
            dispensed_d = 10'd0;
            busy_d      = 1'b1;
            state_d     = S_SELECT;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_SELECT: begin
        eject_d = pick_onehot;
        timer_d = '0;
        state_d = S_EJECT;
      end

      S_EJECT: begin
        if (ejAck) begin
          eject_d     = 6'b000000;
          remaining_d = remaining_q - token_value;
          dispensed_d = dispensed_q + token_value;
          timer_d     = '0;
          state_d     = S_RELEASE;
        end else if (timer_q == TIMER_LAST) begin
          eject_d = 6'b000000;
          fault_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      // The mechanism must drop its ack before the next token is requested.
      S_RELEASE: begin
        if (!ejAck) begin
          state_d = (remaining_q == 10'd0) ? S_DONE : S_SELECT;
        end else if (timer_q == TIMER_LAST) begin
          fault_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      S_FAULT: begin
        if (clrFault) begin
          fault_d     = 1'b0;
          remaining_d = 10'd0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      eject_q     <= 6'b000000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      remaining_q <= 10'd0;
      dispensed_q <= 10'd0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      eject_q     <= eject_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      remaining_q <= remaining_d;
      dispensed_q <= dispensed_d;
      timer_q     <= timer_d;
    end
  end

  assign eject     = eject_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign remaining = remaining_q;
  assign dispensed = dispensed_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a mechanism model answers ejects,
// a negedge monitor pops expected eject/done/fault events as the DUT shows them.
module tb_change_dispenser;

  localparam int unsigned ACK_TIMEOUT = 20;
  localparam int unsigned TW          = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] change = 10'd0;
  logic       start = 1'b0;
  logic       ejAck;
  logic       clrFault = 1'b0;
  logic [5:0] eject;
  logic       busy;
  logic       done;
  logic       fault;
  logic [9:0] remaining;
  logic [9:0] dispensed;

  always #5 clk = ~clk;

  change_dispenser #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .TW(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .change(change),
    .start(start),
    .ejAck(ejAck),
    .clrFault(clrFault),
    .eject(eject),
    .busy(busy),
    .done(done),
    .fault(fault),
    .remaining(remaining),
    .dispensed(dispensed)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Mechanism model: instant follows eject combinationally; delay acks one
  // cycle after eject and drops one cycle after it falls; stall never acks a
  // chosen token; stuck never drops its ack once raised.
  typedef enum int {M_INSTANT, M_DELAY, M_STALL, M_STUCK} mech_t;
  mech_t mode = M_INSTANT;
  int    stall_tok = 0;
  int    tok_cnt = 0;
  logic  ack_reg = 1'b0;
  logic  prev_want = 1'b0;

  assign ejAck = (mode == M_INSTANT) ? (eject != 6'd0) : ack_reg;

  initial forever begin
    logic want;
    @(negedge clk);
    want = (eject != 6'd0);
    if (want && !prev_want) tok_cnt++;
    case (mode)
      M_DELAY: ack_reg = prev_want;
      M_STALL: ack_reg = prev_want && (tok_cnt != stall_tok);
      M_STUCK: ack_reg = ack_reg | prev_want;
      default: ack_reg = 1'b0;
    endcase
    prev_want = want;
  end

  typedef enum int {EV_EJECT, EV_DONE, EV_FAULT} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [9:0] a;
    logic [9:0] b;
  } ev_t;

  ev_t        expq[$];
  logic [9:0] cur_change = 10'd0;
  int         start_cyc = 0;
  int         done_cyc = -1;
  int         fault_cyc = -1;
  int         eject_cyc = -1;
  int         eject_fall_cyc = -1;
  int         done_count = 0;

  task automatic pushEv(input ev_kind_t k, input logic [9:0] a, input logic [9:0] b);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.b    = b;
    expq.push_back(e);
  endtask

  task automatic handleEvent(input ev_kind_t k, input logic [9:0] a, input logic [9:0] b);
    ev_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event: got kind %0d a=%0d b=%0d, expected none", k, a, b);
    end else begin
      e = expq.pop_front();
      checkOutput("event_kind", k, e.kind);
      checkOutput("event_a", a, e.a);
      if (k != EV_EJECT) checkOutput("event_b", b, e.b);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pops on visible events.
  initial begin
    logic [5:0] prev_eject;
    logic       prev_fault;
    prev_eject = 6'd0;
    prev_fault = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("eject_onehot", 32'($countones(eject) <= 1), 32'd1);
        if (busy && !fault)
          checkOutput("conservation", 32'(dispensed) + 32'(remaining), 32'(cur_change));
        if (eject != 6'd0 && prev_eject == 6'd0) begin
          eject_cyc = cyc;
          handleEvent(EV_EJECT, {4'd0, eject}, 10'd0);
        end
        if (eject == 6'd0 && prev_eject != 6'd0) eject_fall_cyc = cyc;
        if (done) begin
          done_cyc = cyc;
          done_count++;
          handleEvent(EV_DONE, dispensed, remaining);
        end
        if (fault && !prev_fault) begin
          fault_cyc = cyc;
          handleEvent(EV_FAULT, dispensed, remaining);
        end
      end
      prev_eject = eject;
      prev_fault = fault;
    end
  end

  task automatic applyStimulus(input logic [9:0] amt, input bit latch);
    @(negedge clk);
    change = amt;
    start  = 1'b1;
    if (latch) begin
      cur_change = amt;
      start_cyc  = cyc;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clrFault = 1'b1;
    @(negedge clk);
    clrFault = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget);
    int n = 0;
    while (done_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    checkOutput("done_within_budget", 32'(done_count >= target), 32'd1);
  endtask

  task automatic waitFault(input int budget);
    int n = 0;
    while (!fault && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    checkOutput("fault_within_budget", 32'(fault), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_eject"}, 32'(eject), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_fault"}, 32'(fault), 32'd0);
    checkOutput({tag, "_remaining"}, 32'(remaining), 32'd0);
    checkOutput({tag, "_dispensed"}, 32'(dispensed), 32'd0);
  endtask

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_done;
    int base_tok;
    int n;

    // Reset values
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Zero change: done next cycle, no eject, never busy
    base_done = done_count;
    base_tok  = tok_cnt;
    pushEv(EV_DONE, 10'd0, 10'd0);
    applyStimulus(10'd0, 1'b1);
    waitDone(base_done + 1, 10);
    checkOutput("zero_done_latency", 32'(done_cyc - start_cyc), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    checkOutput("zero_no_eject", 32'(tok_cnt - base_tok), 32'd0);

    // 37 with one-cycle ack/drop: 10,10,10,5,2
    mode = M_DELAY;
    base_done = done_count;
    pushEv(EV_EJECT, 10'd8, 10'd0);
    pushEv(EV_EJECT, 10'd8, 10'd0);
    pushEv(EV_EJECT, 10'd8, 10'd0);
    pushEv(EV_EJECT, 10'd4, 10'd0);
    pushEv(EV_EJECT, 10'd2, 10'd0);
    pushEv(EV_DONE, 10'd37, 10'd0);
    applyStimulus(10'd37, 1'b1);
    waitDone(base_done + 1, 200);
    repeat (5) @(negedge clk);
    checkOutput("c37_dispensed", 32'(dispensed), 32'd37);
    checkOutput("c37_remaining", 32'(remaining), 32'd0);
    checkOutput("c37_single_done", 32'(done_count - base_done), 32'd1);

    // 500 instant ack, stray start mid-way ignored
    mode = M_INSTANT;
    base_done = done_count;
    for (int i = 0; i < 5; i++) pushEv(EV_EJECT, 10'd32, 10'd0);
    pushEv(EV_DONE, 10'd500, 10'd0);
    applyStimulus(10'd500, 1'b1);
    repeat (5) @(negedge clk);
    applyStimulus(10'd7, 1'b0);
    waitDone(base_done + 1, 100);
    checkOutput("c500_done_latency", 32'(done_cyc - start_cyc), 32'd17);
    checkOutput("c500_dispensed", 32'(dispensed), 32'd500);
    checkOutput("c500_busy", 32'(busy), 32'd0);

    // 60 with second token never acknowledged: 50 then jam on 10
    mode      = M_STALL;
    stall_tok = tok_cnt + 2;
    base_done = done_count;
    pushEv(EV_EJECT, 10'd16, 10'd0);
    pushEv(EV_EJECT, 10'd8, 10'd0);
    pushEv(EV_FAULT, 10'd50, 10'd10);
    applyStimulus(10'd60, 1'b1);
    waitFault(200);
    checkOutput("c60_fault_latency", 32'(fault_cyc - eject_cyc), 32'(ACK_TIMEOUT));
    checkOutput("c60_eject", 32'(eject), 32'd0);
    checkOutput("c60_busy", 32'(busy), 32'd0);
    applyStimulus(10'd5, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("c60_frozen_remaining", 32'(remaining), 32'd10);
    checkOutput("c60_frozen_dispensed", 32'(dispensed), 32'd50);
    pulseClear();
    repeat (3) @(negedge clk);
    checkOutput("c60_cleared_fault", 32'(fault), 32'd0);
    checkOutput("c60_cleared_remaining", 32'(remaining), 32'd0);
    checkOutput("c60_no_done", 32'(done_count - base_done), 32'd0);

    // 11 with ack stuck high after the first token: jam in release
    mode      = M_STUCK;
    base_done = done_count;
    pushEv(EV_EJECT, 10'd8, 10'd0);
    pushEv(EV_FAULT, 10'd10, 10'd1);
    applyStimulus(10'd11, 1'b1);
    waitFault(200);
    checkOutput("c11_fault_latency", 32'(fault_cyc - eject_fall_cyc), 32'(ACK_TIMEOUT));
    checkOutput("c11_eject", 32'(eject), 32'd0);
    pulseClear();
    mode = M_INSTANT;
    repeat (3) @(negedge clk);
    checkOutput("c11_cleared_fault", 32'(fault), 32'd0);
    checkOutput("c11_no_done", 32'(done_count - base_done), 32'd0);

    // Stray clear in idle has no effect
    pulseClear();
    repeat (2) @(negedge clk);
    checkOutput("stray_clear_busy", 32'(busy), 32'd0);
    checkOutput("stray_clear_fault", 32'(fault), 32'd0);

    // Asynchronous reset while ejecting 123, then 3 dispenses 2,1
    mode      = M_STALL;
    stall_tok = tok_cnt + 1;
    base_done = done_count;
    pushEv(EV_EJECT, 10'd32, 10'd0);
    applyStimulus(10'd123, 1'b1);
    n = 0;
    while (eject == 6'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("c123_ejecting", 32'(eject), 32'd32);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkAllZero("async_reset");
    @(negedge clk);
    rst  = 1'b1;
    mode = M_INSTANT;
    pushEv(EV_EJECT, 10'd2, 10'd0);
    pushEv(EV_EJECT, 10'd1, 10'd0);
    pushEv(EV_DONE, 10'd3, 10'd0);
    applyStimulus(10'd3, 1'b1);
    waitDone(base_done + 1, 50);
    repeat (3) @(negedge clk);
    checkOutput("c3_dispensed", 32'(dispensed), 32'd3);
    checkOutput("c3_single_done", 32'(done_count - base_done), 32'd1);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
